scoreboard_wb_regs: RTL and testbench

Wishbone B4 classic target for the scoreboard user project. It answers management-SoC bus cycles on the `wbs_*` lines of the user area and holds the live game state: home and away scores, period, and a run/stop countdown game clock. It drives that state as registered outputs to the display-driver logic that owns the `io_out` pads.

---
 rtl/scoreboard_pkg.sv | 16 +
 rtl/scoreboard_game_timer.sv | 42 ++++
 rtl/scoreboard_wb_regs.sv | 119 +++++++++++
 tb/tb_scoreboard_wb_regs.sv | 119 +++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared register map, field widths, bus FSM state and score step helper
package scoreboard_pkg;
  localparam int SCORE_W  = 8;
  localparam int PERIOD_W = 4;
  localparam int CLOCK_W  = 12;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_SCORE  = 3'd1;
  localparam logic [2:0] REG_PERIOD = 3'd2;
  localparam logic [2:0] REG_CLOCK  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_INC    = 3'd5;
  typedef enum logic {ST_IDLE, ST_ACK} bus_state_e;
  function automatic logic [SCORE_W-1:0] sat_step(input logic [SCORE_W-1:0] v, input logic inc, input logic dec);
    return (inc && !dec && v != '1) ? v + 1'b1 : (dec && !inc && v != '0) ? v - 1'b1 : v;
  endfunction
endpackage

// File: rtl/scoreboard_game_timer.sv
// scoreboard_game_timer: prescaled seconds countdown with sticky expired flag
// Ports: clk_i/rst_i clock and sync reset; load_i/load_val_i load count and zero prescaler;
// run_i enables counting; clr_i clears expired; tick_o terminal-count pulse;
// expired_o sticky flag; count_o seconds remaining.
module scoreboard_game_timer import scoreboard_pkg::*; #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [CLOCK_W-1:0] load_val_i,
  input  logic               run_i,
  input  logic               clr_i,
  output logic               tick_o,
  output logic               expired_o,
  output logic [CLOCK_W-1:0] count_o
);
  logic [23:0] presc_q, presc_d;
  logic [CLOCK_W-1:0] count_q, count_d;
  logic expired_q, expired_d;
  // a load in the same cycle suppresses the tick so the written count wins
  assign tick_o = run_i & (presc_q == TICK_DIV - 24'd1) & ~load_i;
  always_comb begin
    presc_d = load_i ? '0 : run_i ? (tick_o ? '0 : presc_q + 24'd1) : presc_q;
    count_d = load_i ? load_val_i : (tick_o && count_q != '0) ? count_q - 1'b1 : count_q;
    // setting on the 1->0 tick has priority over a concurrent clear
    expired_d = (expired_q & ~clr_i) | (tick_o & (count_q == CLOCK_W'(1)));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      count_q <= '0;
      expired_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      expired_q <= expired_d;
    end
  end
  assign expired_o = expired_q;
  assign count_o = count_q;
endmodule

// File: rtl/scoreboard_wb_regs.sv
// scoreboard_wb_regs: Wishbone B4 classic register target holding live scoreboard state
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wbs_* Wishbone slave bus;
// score_home_o/score_away_o/period_o/clock_sec_o/clock_run_o game state;
// buzzer_o expired flag; irq_o expired and irq_en.
module scoreboard_wb_regs import scoreboard_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [23:0] TICK_DIV  = 24'd10_000_000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [SCORE_W-1:0]  score_home_o,
  output logic [SCORE_W-1:0]  score_away_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic [CLOCK_W-1:0]  clock_sec_o,
  output logic                clock_run_o,
  output logic                buzzer_o,
  output logic                irq_o
);
  bus_state_e state_q, state_d;
  logic [SCORE_W-1:0] home_q, home_d, away_q, away_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic run_q, run_d, irq_en_q, irq_en_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [CLOCK_W-1:0] count, load_val;
  logic req, wr, load, tick, expired;
  logic [2:0] idx;
  logic wr_ctrl, wr_score, wr_period, wr_status, wr_inc;
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};
  assign idx = wbs_adr_i[4:2];
  // the IDLE term keeps a strobe held through the ACK cycle from being accepted twice in a row
  assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & (state_q == ST_IDLE);
  assign wr = req & wbs_we_i;
  assign wr_ctrl = wr & (idx == REG_CTRL) & wbs_sel_i[0];
  assign wr_score = wr & (idx == REG_SCORE);
  assign wr_period = wr & (idx == REG_PERIOD) & wbs_sel_i[0];
  assign wr_status = wr & (idx == REG_STATUS) & wbs_sel_i[0];
  assign wr_inc = wr & (idx == REG_INC) & wbs_sel_i[0];
  assign load = wr & (idx == REG_CLOCK) & (wbs_sel_i[0] | wbs_sel_i[1]);
  assign load_val = {wbs_sel_i[1] ? wbs_dat_i[11:8] : count[11:8], wbs_sel_i[0] ? wbs_dat_i[7:0] : count[7:0]};
  scoreboard_game_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk_i(wb_clk_i),
    .rst_i(wb_rst_i),
    .load_i(load),
    .load_val_i(load_val),
    .run_i(run_q),
    .clr_i(wr_status & wbs_dat_i[0]),
    .tick_o(tick),
    .expired_o(expired),
    .count_o(count)
  );
  always_comb begin
    case (idx)
      REG_CTRL:   rd_val = {29'd0, irq_en_q, 1'b0, run_q};
      REG_SCORE:  rd_val = {16'd0, away_q, home_q};
      REG_PERIOD: rd_val = {28'd0, period_q};
      REG_CLOCK:  rd_val = {20'd0, count};
      REG_STATUS: rd_val = {30'd0, run_q, expired};
      default:    rd_val = '0;
    endcase
  end
  always_comb begin
    state_d = req ? ST_ACK : ST_IDLE;
    rdata_d = (req & ~wbs_we_i) ? rd_val : '0;
    home_d = home_q;
    away_d = away_q;
    if (wr_ctrl && wbs_dat_i[1]) begin
      home_d = '0;
      away_d = '0;
    end
    if (wr_score && wbs_sel_i[0]) home_d = wbs_dat_i[7:0];
    if (wr_score && wbs_sel_i[1]) away_d = wbs_dat_i[15:8];
    if (wr_inc) begin
      home_d = sat_step(home_q, wbs_dat_i[0], wbs_dat_i[2]);
      away_d = sat_step(away_q, wbs_dat_i[1], wbs_dat_i[3]);
    end
    period_d = wr_period ? wbs_dat_i[3:0] : period_q;
    irq_en_d = wr_ctrl ? wbs_dat_i[2] : irq_en_q;
    run_d = wr_ctrl ? wbs_dat_i[0] & (count != '0) : run_q;
    // the expiring tick stops the clock even against a concurrent run write
    if (tick && count == CLOCK_W'(1)) run_d = 1'b0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      home_q <= '0;
      away_q <= '0;
      period_q <= '0;
      irq_en_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      home_q <= home_d;
      away_q <= away_d;
      period_q <= period_d;
      irq_en_q <= irq_en_d;
      run_q <= run_d;
    end
  end
  assign wbs_ack_o = (state_q == ST_ACK);
  assign wbs_dat_o = rdata_q;
  assign score_home_o = home_q;
  assign score_away_o = away_q;
  assign period_o = period_q;
  assign clock_sec_o = count;
  assign clock_run_o = run_q;
  assign buzzer_o = expired;
  assign irq_o = expired & irq_en_q;
endmodule

// File: tb/tb_scoreboard_wb_regs.sv
// tb_scoreboard_wb_regs: directed self-checking bench with a read-data scoreboard queue
module tb_scoreboard_wb_regs;
  import scoreboard_pkg::*;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 1'b0, rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, dat = '0;
  logic ack, run, buzz, irq;
  logic [31:0] rdat;
  logic [7:0] home, away;
  logic [3:0] period;
  logic [11:0] sec;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  scoreboard_wb_regs #(.BASE_ADDR(BASE), .TICK_DIV(24'd4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .score_home_o(home), .score_away_o(away), .period_o(period), .clock_sec_o(sec),
    .clock_run_o(run), .buzzer_o(buzz), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [2:0] r, input logic [3:0] s, input logic [31:0] d, input logic [31:0] e, input string tag);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {27'd0, r, 2'b00}; sel = s; dat = d;
    if (!w) exp_q.push_back(e);
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk({tag, " latency"}, n, 2);
    chk({tag, " rdata"}, rdat, w ? 32'd0 : exp_q.pop_front());
  endtask
  initial begin
    int n;
    logic [3:0] pat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst outs a", {16'd0, home, away}, 0);
    chk("rst outs b", {12'd0, ack, period, sec, run, buzz, irq}, 0);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 3'(i), 4'hf, 0, 0, "rst read");
      @(negedge clk);
      chk("rst single ack", {31'd0, ack}, 0);
    end
    bus(1'b1, REG_SCORE, 4'b0001, 32'h0000_0C07, 0, "score wr");
    chk("score home", {24'd0, home}, 7);
    chk("score away", {24'd0, away}, 0);
    bus(1'b0, REG_SCORE, 4'hf, 0, 32'h0000_0007, "score rd");
    bus(1'b1, REG_SCORE, 4'b0011, 32'h0000_00FE, 0, "score 254");
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, REG_INC, 4'b0001, 32'h1, 0, "inc home");
      chk("inc home sat", {24'd0, home}, 255);
    end
    bus(1'b1, REG_INC, 4'b0001, 32'h8, 0, "dec away");
    chk("dec away sat", {24'd0, away}, 0);
    bus(1'b1, REG_INC, 4'b0001, 32'h5, 0, "inc dec");
    chk("inc dec cancel", {24'd0, home}, 255);
    bus(1'b1, REG_INC, 4'b0001, 32'h4, 0, "dec home");
    chk("dec home", {24'd0, home}, 254);
    bus(1'b0, REG_SCORE, 4'hf, 0, 32'h0000_00FE, "score rd2");
    bus(1'b1, REG_CLOCK, 4'b0011, 32'd2, 0, "clock ld");
    chk("clock ld sec", {20'd0, sec}, 2);
    bus(1'b1, REG_CTRL, 4'b0001, 32'h5, 0, "run irq");
    chk("run on", {31'd0, run}, 1);
    repeat (3) @(negedge clk);
    chk("sec hold 2", {20'd0, sec}, 2);
    @(negedge clk);
    chk("sec 1", {20'd0, sec}, 1);
    repeat (3) @(negedge clk);
    chk("sec hold 1", {20'd0, sec}, 1);
    chk("buzz before", {31'd0, buzz}, 0);
    @(negedge clk);
    chk("sec 0", {20'd0, sec}, 0);
    chk("expire flags", {29'd0, run, buzz, irq}, 3'b011);
    bus(1'b0, REG_STATUS, 4'hf, 0, 32'h1, "status rd");
    bus(1'b1, REG_STATUS, 4'b0001, 32'h1, 0, "w1c");
    chk("w1c flags", {30'd0, buzz, irq}, 0);
    bus(1'b1, REG_CTRL, 4'b0001, 32'h0, 0, "irq off");
    bus(1'b1, REG_CLOCK, 4'b0011, 32'd1, 0, "clock ld1");
    bus(1'b1, REG_CTRL, 4'b0001, 32'h1, 0, "run2");
    repeat (4) @(negedge clk);
    chk("noirq flags", {28'd0, sec[0], run, buzz, irq}, 4'b0010);
    bus(1'b1, REG_CTRL, 4'b0001, 32'h1, 0, "run at 0");
    chk("run ignored", {31'd0, run}, 0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hf;
    n = 0;
    repeat (10) begin @(negedge clk); if (ack) n++; end
    chk("nomatch acks", n, 0);
    adr = BASE | 32'h8;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      pat = {pat[2:0], ack};
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held ack pattern", {28'd0, pat}, 4'b1010);
    bus(1'b1, REG_PERIOD, 4'b0001, 32'h3, 0, "period");
    chk("period", {28'd0, period}, 3);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE | 32'h4; sel = 4'b0001; dat = 32'h55;
    @(negedge clk); @(negedge clk);
    chk("rst mid ack", {31'd0, ack}, 0);
    chk("rst mid outs a", {16'd0, home, away}, 0);
    chk("rst mid outs b", {12'd0, rdat[0], period, sec, run, buzz, irq}, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    bus(1'b0, REG_SCORE, 4'hf, 0, 32'h0, "rst discard");
    bus(1'b0, REG_PERIOD, 4'hf, 0, 32'h0, "rst period");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
